lf_fir_sequencer: RTL

Controller and MAC engine that runs the low-band FIR over the 1024x16 low-frequency sample queue. On each new-sample tick, while the queue reports sequencing, it walks the read port across a TAPS-long window starting at the queue's oldest pointer. In lock-step it steps the coefficient ROM address, accumulates sample*coeff, and emits one saturated 16-bit filtered sample. It sits between the low-frequency queue and its coefficient ROM on one side and the band mixer on the other.

---
 rtl/lf_fir_sequencer.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/lf_fir_sequencer.sv
// Purpose : low-band FIR sequencer. It walks a TAPS-long window of the LF sample queue and the coefficient ROM, accumulating sample*coeff products.
// Latency : dout_vld is asserted TAPS+3 cycles after the accepted smpl_tick; busy covers the TAPS+2 cycles in between.
// Backpres: none. A tick that arrives while busy is dropped and sets the sticky overrun flag.
// Ports   : clk/rst (sync, active-high); smpl_tick/seq_valid/base_ptr start a pass;
//           rd_en/rd_addr/rdata form the queue read port; coeff_addr/coeff form the ROM port;
//           dout/dout_vld carry the result strobe; busy and overrun report status.
module lf_fir_sequencer #(
    parameter int TAPS   = 1021,
    parameter int ADDR_W = 10,
    parameter int DW     = 16,
    parameter int CW     = 16,
    parameter int ACC_W  = 42
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              smpl_tick,
    input  logic              seq_valid,
    input  logic [ADDR_W-1:0] base_ptr,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DW-1:0]     rdata,
    output logic [ADDR_W-1:0] coeff_addr,
    input  logic [CW-1:0]     coeff,
    output logic [DW-1:0]     dout,
    output logic              dout_vld,
    output logic              busy,
    output logic              overrun
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUT} state_t;

    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(TAPS - 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};

    state_t                    state_q;
    logic                      rd_en_q;
    logic [ADDR_W-1:0]         rd_addr_q;
    logic [ADDR_W-1:0]         coeff_addr_q;   // doubles as the tap index k
    logic                      rd_vld_q;       // rdata/coeff hold a product this cycle
    logic                      first_q;        // next product loads instead of adds
    logic signed [ACC_W-1:0]   acc_q;
    logic [DW-1:0]             dout_q;
    logic                      dout_vld_q;
    logic                      busy_q;
    logic                      overrun_q;

    logic signed [DW+CW-1:0]   smp_ext;
    logic signed [DW+CW-1:0]   cof_ext;
    logic signed [DW+CW-1:0]   prod;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   acc_d;
    logic signed [ACC_W-1:0]   shifted;
    logic [DW-1:0]             sat_d;

    always_comb begin
        // Operands are widened to the full product width so the multiply is exact.
        smp_ext  = {{CW{rdata[DW-1]}}, rdata};
        cof_ext  = {{DW{coeff[CW-1]}}, coeff};
        prod     = smp_ext * cof_ext;
        prod_ext = {{(ACC_W-DW-CW){prod[DW+CW-1]}}, prod};

        acc_d = acc_q;
        if (rd_vld_q) begin
            acc_d = first_q ? prod_ext : (acc_q + prod_ext);
        end

        // Remove the Q1.15 coefficient scaling, then clamp to the sample range.
        shifted = acc_q >>> (CW - 1);
        sat_d   = shifted[DW-1:0];
        if (shifted > SAT_MAX) begin
            sat_d = {1'b0, {(DW-1){1'b1}}};
        end else if (shifted < SAT_MIN) begin
            sat_d = {1'b1, {(DW-1){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rd_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            coeff_addr_q <= '0;
            rd_vld_q     <= 1'b0;
            first_q      <= 1'b0;
            acc_q        <= '0;
            dout_q       <= '0;
            dout_vld_q   <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            dout_vld_q <= 1'b0;
            rd_vld_q   <= rd_en_q;
            acc_q      <= acc_d;
            if (rd_vld_q) begin
                first_q <= 1'b0;
            end
            if (smpl_tick && busy_q) begin
                overrun_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (smpl_tick && seq_valid) begin
                        state_q      <= RUN;
                        rd_en_q      <= 1'b1;
                        rd_addr_q    <= base_ptr;
                        coeff_addr_q <= '0;
                        busy_q       <= 1'b1;
                        first_q      <= 1'b1;
                    end
                end
                RUN: begin
                    if (coeff_addr_q == LAST_TAP) begin
                        state_q <= DRAIN;
                        rd_en_q <= 1'b0;
                    end else begin
                        // The address wraps naturally at the ADDR_W boundary.
                        rd_addr_q    <= rd_addr_q + ADDR_W'(1);
                        coeff_addr_q <= coeff_addr_q + ADDR_W'(1);
                    end
                end
                DRAIN: begin
                    state_q <= OUT;
                end
                OUT: begin
                    dout_q     <= sat_d;
                    dout_vld_q <= 1'b1;
                    busy_q     <= 1'b0;
                    state_q    <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rd_en      = rd_en_q;
    assign rd_addr    = rd_addr_q;
    assign coeff_addr = coeff_addr_q;
    assign dout       = dout_q;
    assign dout_vld   = dout_vld_q;
    assign busy       = busy_q;
    assign overrun    = overrun_q;

endmodule
